tinyalu_responder: RTL and testbench

- DUT-side responder for the TinyALU start/done protocol; the counterpart of the testbench BFM that drives A, B, op and start.
- Captures operands and opcode when start is sampled high, then executes the instruction. Add/and/xor/no_op/rst_op complete in a single cycle; mul is multi-cycle.
- Pulses done for one cycle with result valid, then returns to idle.
- Sits directly under the bench interface as the design under test.

---
 rtl/tinyalu_if.sv | 24 ++
 rtl/tinyalu_responder.sv | 143 ++++++++++++++
 tb/tb_tinyalu_responder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/tinyalu_if.sv
// TinyALU start/done bus.
// Groups the request side (A, B, op, start) and the response side
// (done, result, busy) of the TinyALU protocol into one bundle.
//   master : the requester; drives A, B, op and start, observes the response
//   slave  : the responder; observes the request, drives done, result and busy
interface tinyalu_if;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  op;
  logic        start;
  logic        done;
  logic [15:0] result;
  logic        busy;

  modport master (
    output A, B, op, start,
    input  done, result, busy
  );

  modport slave (
    input  A, B, op, start,
    output done, result, busy
  );
endinterface

// File: rtl/tinyalu_responder.sv
// TinyALU responder.
// Captures A, B and op when start is seen in IDLE, executes the instruction
// and pulses done for one cycle with the registered result.
// add/and/xor/no_op/rst_op complete one edge after the capture edge; mul
// completes MUL_LATENCY edges after the capture edge.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : tinyalu_if.slave (A, B, op, start in; done, result, busy out)
module tinyalu_responder #(
  parameter int MUL_LATENCY = 3
) (
  input  logic      clk,
  input  logic      reset,
  tinyalu_if.slave  bus
);

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_RST = 3'b111;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC1 = 2'd1,
    MULT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        capture;
  logic        fin_exec;
  logic        fin_mul;
  logic        done_r;
  logic [15:0] result_r;

  logic [7:0]  a_p0;
  logic [7:0]  b_p0;
  logic [2:0]  op_p0;
  logic [15:0] prod_p1;

  // Single-cycle opcodes; unrecognised codes leave the result untouched.
  function automatic logic [15:0] alu_result(
    input logic [2:0]  op_f,
    input logic [7:0]  a_f,
    input logic [7:0]  b_f,
    input logic [15:0] prev_f
  );
    logic [15:0] r;
    case (op_f)
      OP_ADD:  r = {7'b0, ({1'b0, a_f} + {1'b0, b_f})};
      OP_AND:  r = {8'h00, a_f & b_f};
      OP_XOR:  r = {8'h00, a_f ^ b_f};
      OP_RST:  r = 16'h0000;
      default: r = prev_f;
    endcase
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    fin_exec  = 1'b0;
    fin_mul   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          capture = 1'b1;
          if (bus.op == OP_MUL) begin
            state_nxt = MULT;
            cnt_nxt   = MUL_LOAD;
          end else begin
            state_nxt = EXEC1;
          end
        end
      end
      EXEC1: begin
        fin_exec  = 1'b1;
        state_nxt = DONE;
      end
      MULT: begin
        // Loaded with MUL_LATENCY-1, the counter walks down to zero and the
        // edge taken with it at zero is the MUL_LATENCY-th after capture.
        if (cnt == 4'd0) begin
          fin_mul   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      done_r   <= 1'b0;
      result_r <= 16'h0000;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      done_r <= fin_exec | fin_mul;
      if (fin_exec) begin
        result_r <= alu_result(op_p0, a_p0, b_p0, result_r);
      end else if (fin_mul) begin
        result_r <= prod_p1;
      end
    end
  end

  // Stage p0: operand capture at the start-sample edge.
  always_ff @(posedge clk) begin
    if (capture) begin
      a_p0  <= bus.A;
      b_p0  <= bus.B;
      op_p0 <= bus.op;
    end
  end

  // Stage p1: registered product; settled one edge after capture, which is
  // never later than the completing edge since MUL_LATENCY >= 2.
  always_ff @(posedge clk) begin
    prod_p1 <= 16'(a_p0) * 16'(b_p0);
  end

  // Gated with reset so neither flag is ever seen high while reset is held.
  assign bus.done   = done_r & ~reset;
  assign bus.busy   = (state != IDLE) & ~reset;
  assign bus.result = result_r;

endmodule

// File: tb/tb_tinyalu_responder.sv
module tb_tinyalu_responder;
  localparam int MUL_LATENCY = 3;

  logic clk;
  logic reset;
  int   cyc;

  tinyalu_if bus();

  tinyalu_responder #(.MUL_LATENCY(MUL_LATENCY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] model_result = 16'h0000;
  logic [15:0] held_result  = 16'h0000;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: what each opcode produces, from the opcode table.
  function automatic logic [15:0] ref_result(input logic [2:0] o, input logic [7:0] a,
                                             input logic [7:0] b, input logic [15:0] prev);
    case (o)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      3'd7:    return 16'h0000;
      default: return prev;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o);
    return (o == 3'd4) ? MUL_LATENCY : 1;
  endfunction

  // Called just after the edge that sampled start; cyc is that edge's index.
  task automatic expect_txn(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    model_result = ref_result(o, a, b, model_result);
    e.res = model_result;
    e.due = cyc + ref_latency(o);
    sb.push_back(e);
  endtask

  // One instruction with a single-cycle start; operands are scrambled while
  // it is in flight, then the bench returns with the DUT idle.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
    bus.A = a; bus.B = b; bus.op = o; bus.start = 1'b1;
    @(posedge clk); #1;
    expect_txn(o, a, b);
    bus.start = 1'b0;
    repeat (ref_latency(o) + 1) begin
      @(posedge clk); #1;
      bus.A  = 8'($urandom);
      bus.B  = 8'($urandom);
      bus.op = 3'($urandom);
    end
  endtask

  // Monitor: pops the scoreboard on each done and checks timing and value.
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", 32'(bus.busy), 32'(sb.size() > 0));
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_done: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.due));
          check("result", 32'(bus.result), 32'(e.res));
          held_result = e.res;
        end
      end else begin
        check("result_hold", 32'(bus.result), 32'(held_result));
        if (sb.size() > 0 && cyc > sb[0].due) begin
          n_cmp++;
          n_bad++;
          $display("FAIL missing_done: got none expected done at cycle %0d (now %0d)", sb[0].due, cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.A = 8'h00; bus.B = 8'h00; bus.op = 3'd0; bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_result", 32'(bus.result), 32'h0);
    check("reset_done", 32'(bus.done), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    issue(8'hFF, 8'h01, 3'd1);
    issue(8'hF0, 8'h3C, 3'd2);
    issue(8'hF0, 8'h3C, 3'd3);
    issue(8'hFF, 8'hFF, 3'd4);
    issue(8'h12, 8'h34, 3'd7);
    issue(8'h55, 8'h66, 3'd0);
    issue(8'h77, 8'h88, 3'd6);

    // Reset one cycle into a mul: the mul must never complete.
    bus.A = 8'h10; bus.B = 8'h10; bus.op = 3'd4; bus.start = 1'b1;
    @(posedge clk); #1;
    expect_txn(3'd4, 8'h10, 8'h10);
    bus.start = 1'b0;
    reset = 1'b1;
    sb.delete();
    model_result = 16'h0000;
    @(posedge clk); #1;
    reset = 1'b0;
    held_result = 16'h0000;
    @(negedge clk);
    check("abort_result", 32'(bus.result), 32'h0);
    repeat (MUL_LATENCY + 3) @(posedge clk);
    #1;
    issue(8'h02, 8'h03, 3'd1);

    // start held high: the second add uses operands present in the IDLE cycle.
    bus.A = 8'h01; bus.B = 8'h01; bus.op = 3'd1; bus.start = 1'b1;
    @(posedge clk); #1;
    expect_txn(3'd1, 8'h01, 8'h01);
    bus.A = 8'h02; bus.B = 8'h02;
    repeat (2) @(posedge clk);
    #1;
    @(posedge clk); #1;
    expect_txn(3'd1, 8'h02, 8'h02);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      issue(8'($urandom), 8'($urandom), 3'($urandom));
    end

    repeat (MUL_LATENCY + 3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
